ahb_apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge serving eight APB peripherals.
- Decodes each AHB transfer to one PSELx line and runs the APB SETUP/ACCESS sequence.
- Stalls AHB with HREADYout until the selected peripheral's PREADY, then returns PRDATA or a two-cycle ERROR response.
- Sits between the system AHB interconnect and the APB peripheral bus.

---
 rtl/ahb_apb_bridge_if.sv | 35 +++
 rtl/ahb_apb_bridge.sv | 121 ++++++++++++
 tb/tb_ahb_apb_bridge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_if.sv
// rtl/ahb_apb_bridge_if.sv - AHB-Lite and APB bus bundle for the bridge
// slave: the bridge's view (AHB slave, APB master); master: the surrounding system.
interface ahb_apb_bridge_if;
  logic            HSEL;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [31:0]     HWDATA;
  logic            HREADYin;
  logic [31:0]     HRDATA;
  logic            HREADYout;
  logic            HRESP;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE;
  logic            PENABLE;
  logic [7:0]      PSELx;
  logic [7:0][31:0] PRDATA;
  logic [7:0]      PREADY;
  logic [7:0]      PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADYin,
    output HRDATA, HREADYout, HRESP,
    output PADDR, PWDATA, PWRITE, PENABLE, PSELx,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADYin,
    input  HRDATA, HREADYout, HRESP,
    input  PADDR, PWDATA, PWRITE, PENABLE, PSELx,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-Lite slave to eight-peripheral APB master bridge
// Single-clock bridge; every AHB transfer becomes one APB SETUP/ACCESS sequence.
module ahb_apb_bridge #(
  parameter int SEL_LSB = 28,
  parameter int NSLV    = 8
) (
  input  logic             clk,
  input  logic             HRESETn,
  ahb_apb_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [2:0]  idx_q, idx_d;

  logic            valid;
  logic            accept;
  logic            sel_ready;
  logic            sel_err;
  logic [NSLV-1:0] sel_onehot;
  logic            unused_htrans0;

  assign valid          = bus.HSEL & bus.HREADYin & bus.HTRANS[1];
  assign sel_onehot     = NSLV'(1) << idx_q;
  assign sel_ready      = bus.PREADY[idx_q];
  assign sel_err        = bus.PSLVERR[idx_q];
  assign unused_htrans0 = bus.HTRANS[0];

  assign bus.PADDR  = paddr_q;
  assign bus.PWDATA = pwdata_q;
  assign bus.PWRITE = pwrite_q;

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    idx_d         = idx_q;
    accept        = 1'b0;
    bus.PSELx     = '0;
    bus.PENABLE   = 1'b0;
    bus.HREADYout = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;

    case (state_q)
      IDLE: begin
        accept = 1'b1;
      end
      WWAIT: begin
        bus.HREADYout = 1'b0;
        pwdata_d      = bus.HWDATA;
        state_d       = SETUP;
      end
      SETUP: begin
        bus.PSELx     = sel_onehot;
        bus.HREADYout = 1'b0;
        state_d       = ACCESS;
      end
      ACCESS: begin
        bus.PSELx   = sel_onehot;
        bus.PENABLE = 1'b1;
        if (!sel_ready) begin
          bus.HREADYout = 1'b0;
        end else if (sel_err) begin
          bus.HREADYout = 1'b0;
          bus.HRESP     = 1'b1;
          state_d       = ERR2;
        end else begin
          // Completing cycle doubles as an IDLE cycle so transfers run back-to-back.
          accept  = 1'b1;
          state_d = IDLE;
          if (!pwrite_q) begin
            bus.HRDATA = bus.PRDATA[idx_q];
          end
        end
      end
      ERR2: begin
        bus.HRESP = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept && valid) begin
      paddr_d  = bus.HADDR;
      pwrite_d = bus.HWRITE;
      idx_d    = bus.HADDR[SEL_LSB+2:SEL_LSB];
      state_d  = bus.HWRITE ? WWAIT : SETUP;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - scoreboard bench for ahb_apb_bridge
// Driver pushes expected APB/AHB responses at address acceptance; a negedge monitor pops and checks.
module tb_ahb_apb_bridge;

  logic clk = 1'b0;
  logic HRESETn;

  ahb_apb_bridge_if bus ();

  ahb_apb_bridge dut (
    .clk     (clk),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [7:0]  psel;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  exp_t bq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int err_phase = 0;
  int wcnt = 0;

  logic [31:0] cfg_rdata[8];
  int          cfg_wait[8];
  logic        cfg_err[8];

  assign bus.HREADYin = bus.HREADYout;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model; unselected slaves assert PREADY/PSLVERR to prove they are ignored.
  always_comb begin
    bus.PREADY  = '1;
    bus.PSLVERR = '1;
    bus.PRDATA  = '0;
    for (int i = 0; i < 8; i++) begin
      bus.PRDATA[i] = cfg_rdata[i];
      if (bus.PSELx[i]) begin
        bus.PREADY[i]  = bus.PENABLE && (wcnt >= cfg_wait[i]);
        bus.PSLVERR[i] = cfg_err[i];
      end
    end
  end

  always @(posedge clk) begin
    if (bus.PENABLE && ((bus.PSELx & bus.PREADY) == 8'h00))
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (HRESETn) begin
      chk("psel_multihot", 32'($countones(bus.PSELx) > 1), 32'd0);
      chk("penable_without_psel", 32'(bus.PENABLE && (bus.PSELx == 8'h00)), 32'd0);

      if (err_phase == 1) begin
        chk("err2_hresp", 32'(bus.HRESP), 32'd1);
        chk("err2_hready", 32'(bus.HREADYout), 32'd1);
        chk("err2_psel", 32'(bus.PSELx), 32'd0);
        chk("err2_penable", 32'(bus.PENABLE), 32'd0);
        err_phase = 2;
      end else if (err_phase == 2) begin
        chk("post_err_hresp", 32'(bus.HRESP), 32'd0);
        chk("post_err_hready", 32'(bus.HREADYout), 32'd1);
        err_phase = 0;
      end

      if (bus.PSELx != 8'h00 && !bus.PENABLE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_setup", 32'(bus.PSELx), 32'd0);
        end else begin
          e = exp_q[0];
          chk("setup_psel", 32'(bus.PSELx), 32'(e.psel));
          chk("setup_paddr", bus.PADDR, e.addr);
          chk("setup_pwrite", 32'(bus.PWRITE), 32'(e.write));
          if (e.write) chk("setup_pwdata", bus.PWDATA, e.wdata);
          chk("setup_hready", 32'(bus.HREADYout), 32'd0);
        end
      end else if (bus.PENABLE && bus.PSELx != 8'h00) begin
        if ((bus.PSELx & bus.PREADY) == 8'h00) begin
          chk("wait_hready", 32'(bus.HREADYout), 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_access", 32'(bus.PSELx), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("access_psel", 32'(bus.PSELx), 32'(e.psel));
          chk("access_paddr", bus.PADDR, e.addr);
          chk("access_pwrite", 32'(bus.PWRITE), 32'(e.write));
          if (e.write) chk("access_pwdata", bus.PWDATA, e.wdata);
          chk("latency", 32'(cyc - e.start + 1), 32'(e.lat));
          if (e.err) begin
            chk("err1_hresp", 32'(bus.HRESP), 32'd1);
            chk("err1_hready", 32'(bus.HREADYout), 32'd0);
            err_phase = 1;
          end else begin
            chk("ok_hresp", 32'(bus.HRESP), 32'd0);
            chk("ok_hready", 32'(bus.HREADYout), 32'd1);
            if (!e.write) chk("hrdata", bus.HRDATA, e.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ready(output int acc_cyc);
    int   n;
    logic rdy;
    n = 0;
    acc_cyc = 0;
    do begin
      @(negedge clk);
      rdy = bus.HREADYout;
      acc_cyc = cyc;
      n++;
      @(posedge clk);
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL hready_timeout: HREADYout stayed %b, required 1", rdy);
    end
    #1;
  endtask

  function automatic void add(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                              input logic [7:0] psel, input logic [31:0] rdata, input logic err,
                              input int lat);
    exp_t e;
    e.addr = addr; e.write = write; e.wdata = wdata; e.psel = psel;
    e.rdata = rdata; e.err = err; e.lat = lat; e.start = 0;
    bq.push_back(e);
  endfunction

  task automatic run_burst();
    int   ac;
    exp_t e;
    for (int i = 0; i < bq.size(); i++) begin
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = bq[i].addr;
      bus.HWRITE = bq[i].write;
      wait_ready(ac);
      e = bq[i];
      e.start = ac;
      exp_q.push_back(e);
      bus.HWDATA = bq[i].wdata;
      if (i == bq.size() - 1) begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
      end
    end
    wait_ready(ac);
    bq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_psel"}, 32'(bus.PSELx), 32'd0);
    chk({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
    chk({tag, "_pwrite"}, 32'(bus.PWRITE), 32'd0);
    chk({tag, "_paddr"}, bus.PADDR, 32'd0);
    chk({tag, "_pwdata"}, bus.PWDATA, 32'd0);
    chk({tag, "_hrdata"}, bus.HRDATA, 32'd0);
    chk({tag, "_hready"}, 32'(bus.HREADYout), 32'd1);
    chk({tag, "_hresp"}, 32'(bus.HRESP), 32'd0);
  endtask

  initial begin
    int   ac;
    exp_t e;
    HRESETn    = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = '0;
    for (int i = 0; i < 8; i++) begin
      cfg_rdata[i] = 32'h0;
      cfg_wait[i]  = 0;
      cfg_err[i]   = 1'b0;
    end
    cfg_rdata[0] = 32'hA5A5_0000;
    cfg_rdata[3] = 32'h3333_3333;
    cfg_rdata[5] = 32'h1234_5678;
    cfg_rdata[6] = 32'h6666_6666;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("in_reset");
    @(posedge clk);
    #1 HRESETn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");
    @(posedge clk);
    #1;

    add(32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 8'h08, 32'h0, 1'b0, 4);
    run_burst();

    cfg_wait[5] = 3;
    add(32'h5000_0004, 1'b0, 32'h0, 8'h20, 32'h1234_5678, 1'b0, 6);
    run_burst();
    cfg_wait[5] = 0;

    cfg_err[2] = 1'b1;
    add(32'h2000_0008, 1'b1, 32'h0BAD_F00D, 8'h04, 32'h0, 1'b1, 4);
    run_burst();
    cfg_err[2] = 1'b0;

    add(32'h0000_0040, 1'b0, 32'h0,         8'h01, 32'hA5A5_0000, 1'b0, 3);
    add(32'h7000_00FC, 1'b1, 32'hCAFE_0007, 8'h80, 32'h0,         1'b0, 4);
    add(32'hE000_0000, 1'b0, 32'h0,         8'h40, 32'h6666_6666, 1'b0, 3);
    run_burst();

    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b01;
    bus.HADDR  = 32'h1000_0000;
    repeat (3) @(posedge clk);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b10;
    repeat (2) @(posedge clk);
    #1 bus.HTRANS = 2'b00;
    @(negedge clk);
    chk("busy_ignored_psel", 32'(bus.PSELx), 32'd0);
    @(posedge clk);
    #1;

    cfg_wait[3] = 20;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 32'h3000_0100;
    bus.HWRITE = 1'b0;
    wait_ready(ac);
    e.addr = 32'h3000_0100; e.write = 1'b0; e.wdata = 32'h0; e.psel = 8'h08;
    e.rdata = 32'h3333_3333; e.err = 1'b0; e.lat = 23; e.start = ac;
    exp_q.push_back(e);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    repeat (3) @(negedge clk);
    chk("mid_penable_before", 32'(bus.PENABLE), 32'd1);
    #1 HRESETn = 1'b0;
    #1;
    chk("mid_psel_async", 32'(bus.PSELx), 32'd0);
    chk("mid_penable_async", 32'(bus.PENABLE), 32'd0);
    chk("mid_hready_async", 32'(bus.HREADYout), 32'd1);
    exp_q.delete();
    cfg_wait[3] = 0;
    repeat (2) @(posedge clk);
    #1 HRESETn = 1'b1;
    @(posedge clk);
    #1;

    add(32'h3000_0100, 1'b0, 32'h0, 8'h08, 32'h3333_3333, 1'b0, 3);
    run_burst();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
